// File: rtl/io_mux_pkg.sv
// Shared definitions for the configurable pad multiplexer: register offsets,
// function select codes and internal register-select encoding.
package io_mux_pkg;

  localparam int unsigned FUNC_SEL_W    = 2;
  localparam int unsigned PADS_PER_FSEL = 16;

  typedef enum logic [FUNC_SEL_W-1:0] {
    FUNC_GPIO = 2'd0,
    FUNC_ALT1 = 2'd1,
    FUNC_ALT2 = 2'd2,
    FUNC_ALT3 = 2'd3
  } func_e;

  // Decoded register group for the current bus address.
  typedef enum logic [2:0] {
    REG_NONE,
    REG_FSEL,
    REG_INPUT,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_RISE_FLAG,
    REG_FALL_FLAG
  } reg_sel_e;

  localparam logic [7:0] IO_MUX_FUNC_SEL0     = 8'h00;
  localparam logic [7:0] IO_MUX_FUNC_SEL1     = 8'h04;
  localparam logic [7:0] IO_MUX_FUNC_SEL2     = 8'h08;
  localparam logic [7:0] IO_MUX_FUNC_SEL3     = 8'h0C;
  localparam logic [7:0] IO_MUX_INPUT_LO      = 8'h10;
  localparam logic [7:0] IO_MUX_INPUT_HI      = 8'h14;
  localparam logic [7:0] IO_MUX_RISE_EN_LO    = 8'h18;
  localparam logic [7:0] IO_MUX_RISE_EN_HI    = 8'h1C;
  localparam logic [7:0] IO_MUX_FALL_EN_LO    = 8'h20;
  localparam logic [7:0] IO_MUX_FALL_EN_HI    = 8'h24;
  localparam logic [7:0] IO_MUX_RISE_FLAG_LO  = 8'h28;
  localparam logic [7:0] IO_MUX_RISE_FLAG_HI  = 8'h2C;
  localparam logic [7:0] IO_MUX_FALL_FLAG_LO  = 8'h30;
  localparam logic [7:0] IO_MUX_FALL_FLAG_HI  = 8'h34;

endpackage

// File: rtl/io_input_filter.sv
// Per-pad input conditioning: synchroniser, optional glitch filter and
// previous-value flop for edge detection.
// Build option: define IO_MUX_FILTER_EN to include the glitch filter;
// otherwise the synchronised value is used directly and FILTER_CYCLES is unused.
module io_input_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pad,
  output logic filtered,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_filt;
  logic                   r_prev;

  // Synchroniser shift chain, cleared on reset so no stale value leaks out.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef IO_MUX_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_sync != r_filt) begin
      if (r_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = w_sync;
`endif

  // Previous filtered value; reset to 0 together with the filter output.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_filt;
  end

  assign filtered = w_filt;
  assign rise     = w_filt & ~r_prev;
  assign fall     = ~w_filt & r_prev;

endmodule

// File: rtl/io_mux_configurable.sv
// Runtime-configurable pad multiplexer: bus-programmable function select per
// pad, conditioned inputs with edge flags and a registered interrupt.
// Build option: IO_MUX_FILTER_EN enables the per-pad glitch filter.
module io_mux_configurable
  import io_mux_pkg::*;
#(
  parameter int unsigned PIN_COUNT     = 38,
  parameter int unsigned FUNC_COUNT    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 peripheralBus_we,
  input  logic                 peripheralBus_oe,
  input  logic [7:0]           peripheralBus_address,
  input  logic [31:0]          peripheralBus_dataWrite,
  output logic [31:0]          peripheralBus_dataRead,
  output logic                 peripheralBus_ack,
  input  logic [PIN_COUNT-1:0] gpio_output,
  input  logic [PIN_COUNT-1:0] gpio_oeb,
  output logic [PIN_COUNT-1:0] gpio_input,
  input  logic [((FUNC_COUNT > 1) ? PIN_COUNT*(FUNC_COUNT-1) : 1)-1:0] alt_out,
  input  logic [((FUNC_COUNT > 1) ? PIN_COUNT*(FUNC_COUNT-1) : 1)-1:0] alt_oeb,
  output logic [PIN_COUNT-1:0] alt_in,
  input  logic [PIN_COUNT-1:0] io_in,
  output logic [PIN_COUNT-1:0] io_out,
  output logic [PIN_COUNT-1:0] io_oeb,
  output logic                 irq
);

  func_e                r_func_sel [PIN_COUNT];
  logic [PIN_COUNT-1:0] r_rise_en;
  logic [PIN_COUNT-1:0] r_fall_en;
  logic [PIN_COUNT-1:0] r_rise_flag;
  logic [PIN_COUNT-1:0] r_fall_flag;
  logic                 r_irq;
  logic                 r_ack;
  logic [31:0]          r_rdata;

  logic [PIN_COUNT-1:0] w_filtered;
  logic [PIN_COUNT-1:0] w_rise;
  logic [PIN_COUNT-1:0] w_fall;

  reg_sel_e             w_sel;
  logic                 w_hi;
  logic [1:0]           w_fsel_word;
  logic [63:0]          w_wbits64;
  logic [63:0]          w_hmask64;
  logic [31:0]          w_rdata;
  logic [63:0]          w_input64;
  logic [63:0]          w_rise_en64;
  logic [63:0]          w_fall_en64;
  logic [63:0]          w_rise_flag64;
  logic [63:0]          w_fall_flag64;

  for (genvar g = 0; g < PIN_COUNT; g++) begin : g_pad
    io_input_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .i_pad    (io_in[g]),
      .filtered (w_filtered[g]),
      .rise     (w_rise[g]),
      .fall     (w_fall[g])
    );
  end

  assign gpio_input = w_filtered;
  assign alt_in     = w_filtered;

  // Output mux: codes at or above FUNC_COUNT fall through to the undriven default.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int unsigned p = 0; p < PIN_COUNT; p++) begin
      if (r_func_sel[p] == FUNC_GPIO) begin
        io_out[p] = gpio_output[p];
        io_oeb[p] = gpio_oeb[p];
      end
      for (int unsigned f = 1; f < FUNC_COUNT; f++) begin
        if (32'(r_func_sel[p]) == f) begin
          io_out[p] = alt_out[(f-1)*PIN_COUNT + p];
          io_oeb[p] = alt_oeb[(f-1)*PIN_COUNT + p];
        end
      end
    end
  end

  // Address decode into register group, word half and select-word index.
  always_comb begin
    w_sel       = REG_NONE;
    w_hi        = peripheralBus_address[2];
    w_fsel_word = peripheralBus_address[3:2];
    case (peripheralBus_address)
      IO_MUX_FUNC_SEL0, IO_MUX_FUNC_SEL1,
      IO_MUX_FUNC_SEL2, IO_MUX_FUNC_SEL3:         w_sel = REG_FSEL;
      IO_MUX_INPUT_LO,     IO_MUX_INPUT_HI:       w_sel = REG_INPUT;
      IO_MUX_RISE_EN_LO,   IO_MUX_RISE_EN_HI:     w_sel = REG_RISE_EN;
      IO_MUX_FALL_EN_LO,   IO_MUX_FALL_EN_HI:     w_sel = REG_FALL_EN;
      IO_MUX_RISE_FLAG_LO, IO_MUX_RISE_FLAG_HI:   w_sel = REG_RISE_FLAG;
      IO_MUX_FALL_FLAG_LO, IO_MUX_FALL_FLAG_HI:   w_sel = REG_FALL_FLAG;
      default:                                    w_sel = REG_NONE;
    endcase
  end

  // Pair registers are handled as 64-bit pad vectors; the bus word lands in one half.
  always_comb begin
    w_wbits64 = w_hi ? {peripheralBus_dataWrite, 32'h0} : {32'h0, peripheralBus_dataWrite};
    w_hmask64 = w_hi ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
  end

  // Zero-extended 64-bit views so unimplemented pads read as 0.
  always_comb begin
    w_input64     = '0;
    w_rise_en64   = '0;
    w_fall_en64   = '0;
    w_rise_flag64 = '0;
    w_fall_flag64 = '0;
    w_input64[PIN_COUNT-1:0]     = w_filtered;
    w_rise_en64[PIN_COUNT-1:0]   = r_rise_en;
    w_fall_en64[PIN_COUNT-1:0]   = r_fall_en;
    w_rise_flag64[PIN_COUNT-1:0] = r_rise_flag;
    w_fall_flag64[PIN_COUNT-1:0] = r_fall_flag;
  end

  // Read data selection for the addressed register.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_FSEL: begin
        for (int unsigned p = 0; p < PIN_COUNT; p++) begin
          if ((p / PADS_PER_FSEL) == 32'(w_fsel_word))
            w_rdata[FUNC_SEL_W*(p % PADS_PER_FSEL) +: FUNC_SEL_W] = r_func_sel[p];
        end
      end
      REG_INPUT:     w_rdata = w_hi ? w_input64[63:32]     : w_input64[31:0];
      REG_RISE_EN:   w_rdata = w_hi ? w_rise_en64[63:32]   : w_rise_en64[31:0];
      REG_FALL_EN:   w_rdata = w_hi ? w_fall_en64[63:32]   : w_fall_en64[31:0];
      REG_RISE_FLAG: w_rdata = w_hi ? w_rise_flag64[63:32] : w_rise_flag64[31:0];
      REG_FALL_FLAG: w_rdata = w_hi ? w_fall_flag64[63:32] : w_fall_flag64[31:0];
      default:       w_rdata = '0;
    endcase
  end

  // Configuration registers: function selects and interrupt enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < PIN_COUNT; p++) r_func_sel[p] <= FUNC_GPIO;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (peripheralBus_we) begin
      for (int unsigned p = 0; p < PIN_COUNT; p++) begin
        if (w_sel == REG_FSEL && (p / PADS_PER_FSEL) == 32'(w_fsel_word))
          r_func_sel[p] <= func_e'(peripheralBus_dataWrite[FUNC_SEL_W*(p % PADS_PER_FSEL) +: FUNC_SEL_W]);
        if (w_sel == REG_RISE_EN && w_hmask64[p]) r_rise_en[p] <= w_wbits64[p];
        if (w_sel == REG_FALL_EN && w_hmask64[p]) r_fall_en[p] <= w_wbits64[p];
      end
    end
  end

  // Edge flags: a new edge takes priority over a write-1-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise_flag <= '0;
      r_fall_flag <= '0;
    end else begin
      for (int unsigned p = 0; p < PIN_COUNT; p++) begin
        if (w_rise[p])
          r_rise_flag[p] <= 1'b1;
        else if (peripheralBus_we && w_sel == REG_RISE_FLAG && w_hmask64[p] && w_wbits64[p])
          r_rise_flag[p] <= 1'b0;
        if (w_fall[p])
          r_fall_flag[p] <= 1'b1;
        else if (peripheralBus_we && w_sel == REG_FALL_FLAG && w_hmask64[p] && w_wbits64[p])
          r_fall_flag[p] <= 1'b0;
      end
    end
  end

  // Bus response: every strobe, mapped or not, acks one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= peripheralBus_we | peripheralBus_oe;
      r_rdata <= peripheralBus_oe ? w_rdata : '0;
    end
  end

  // Registered interrupt from enabled flags.
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (|(r_rise_flag & r_rise_en)) | (|(r_fall_flag & r_fall_en));
  end

  assign peripheralBus_ack      = r_ack;
  assign peripheralBus_dataRead = r_rdata;
  assign irq                    = r_irq;

endmodule

// File: tb/tb_io_mux_configurable.sv
// Directed self-checking bench for io_mux_configurable (default parameters).
module tb_io_mux_configurable;

  localparam int unsigned P     = 38;
  localparam int unsigned F     = 4;
  localparam int unsigned S     = 2;
  localparam int unsigned FC    = 4;
  localparam int unsigned ALT_W = P * (F - 1);
`ifdef IO_MUX_FILTER_EN
  localparam bit          FILT  = 1'b1;
  localparam int unsigned LAT   = S + FC;
`else
  localparam bit          FILT  = 1'b0;
  localparam int unsigned LAT   = S;
`endif

  logic             clk;
  logic             rst;
  logic             we, oe;
  logic [7:0]       address;
  logic [31:0]      dataWrite, dataRead;
  logic             ack;
  logic [P-1:0]     gpio_output, gpio_oeb, gpio_input;
  logic [ALT_W-1:0] alt_out, alt_oeb;
  logic [P-1:0]     alt_in, io_in, io_out, io_oeb;
  logic             irq;

  int n_assert = 0;
  int n_fail   = 0;

  io_mux_configurable #(
    .PIN_COUNT     (P),
    .FUNC_COUNT    (F),
    .SYNC_STAGES   (S),
    .FILTER_CYCLES (FC)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .peripheralBus_we        (we),
    .peripheralBus_oe        (oe),
    .peripheralBus_address   (address),
    .peripheralBus_dataWrite (dataWrite),
    .peripheralBus_dataRead  (dataRead),
    .peripheralBus_ack       (ack),
    .gpio_output             (gpio_output),
    .gpio_oeb                (gpio_oeb),
    .gpio_input              (gpio_input),
    .alt_out                 (alt_out),
    .alt_oeb                 (alt_oeb),
    .alt_in                  (alt_in),
    .io_in                   (io_in),
    .io_out                  (io_out),
    .io_oeb                  (io_oeb),
    .irq                     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, output logic ak);
    we = 1'b1; address = a; dataWrite = d;
    tick();
    we = 1'b0;
    ak = ack;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic ak);
    oe = 1'b1; address = a;
    tick();
    oe = 1'b0;
    d  = dataRead;
    ak = ack;
  endtask

  logic [31:0] rd;
  logic        ak;
  int          k;
  bit          seen;
  logic [7:0]  rst_addrs [5];

  initial begin
    rst = 1'b1; we = 1'b0; oe = 1'b0; address = '0; dataWrite = '0;
    gpio_output = '0; gpio_oeb = '1; alt_out = '0; alt_oeb = '1; io_in = '0;
    gpio_output[5] = 1'b1; gpio_oeb[5] = 1'b0;
    rst_addrs[0] = 8'h00; rst_addrs[1] = 8'h10; rst_addrs[2] = 8'h18;
    rst_addrs[3] = 8'h28; rst_addrs[4] = 8'h34;

    // Reset state
    repeat (3) tick();
    check("rst_io_out5", io_out[5], 1);
    check("rst_io_oeb5", io_oeb[5], 0);
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    check("rst_dataRead", dataRead, 0);
    check("rst_gpio_input", gpio_input, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_read(rst_addrs[i], rd, ak);
      check($sformatf("rst_read_%0h", rst_addrs[i]), rd, 0);
      check($sformatf("rst_read_ack_%0h", rst_addrs[i]), ak, 1);
    end

    // Function select: pad 5 to alternate function 1
    alt_out[5] = 1'b0; alt_oeb[5] = 1'b0;
    alt_out[P+6] = 1'b1; alt_oeb[P+6] = 1'b0;
    alt_out[2*P+37] = 1'b1; alt_oeb[2*P+37] = 1'b0;
    we = 1'b1; address = 8'h00; dataWrite = 32'h0000_0400;
    #1;
    check("fsel_before_edge", io_out[5], 1);
    tick();
    we = 1'b0;
    check("fsel_io_out5", io_out[5], 0);
    check("fsel_io_oeb5", io_oeb[5], 0);
    check("fsel_wr_ack", ack, 1);
    bus_read(8'h00, rd, ak);
    check("fsel_readback", rd, 32'h0000_0400);
    check("fsel_read_ack", ak, 1);
    tick();
    check("ack_single_pulse", ack, 0);

    bus_write(8'h00, 32'h0000_2400, ak);
    check("fsel_alt2_out6", io_out[6], 1);
    check("fsel_alt2_oeb6", io_oeb[6], 0);
    bus_write(8'h08, 32'hFFFF_FFFF, ak);
    check("fsel_alt3_out37", io_out[37], 1);
    check("fsel_alt3_oeb32", io_oeb[32], 1);
    bus_read(8'h08, rd, ak);
    check("fsel2_readback", rd, 32'h0000_0FFF);
    bus_write(8'h08, 32'h0, ak);
    check("fsel_back_gpio37", io_oeb[37], 1);

    // Back-to-back: write then read issued while ack is high
    we = 1'b1; address = 8'h04; dataWrite = 32'h0000_0005;
    tick();
    we = 1'b0; oe = 1'b1;
    tick();
    oe = 1'b0;
    check("b2b_ack", ack, 1);
    check("b2b_data", dataRead, 32'h0000_0005);

    // Short pulse on pad 7
    io_in[7] = 1'b1;
    repeat (3) tick();
    io_in[7] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (gpio_input[7] === 1'b1) seen = 1'b1;
      tick();
    end
    check("short_pulse_seen", seen, !FILT);
    bus_read(8'h10, rd, ak);
    check("short_pulse_input", rd[7], 0);
    bus_read(8'h28, rd, ak);
    check("short_pulse_rflag", rd, FILT ? 32'h0 : 32'h80);
    bus_write(8'h28, 32'hFFFF_FFFF, ak);
    bus_write(8'h30, 32'hFFFF_FFFF, ak);
    bus_read(8'h28, rd, ak);
    check("rflag_cleared", rd, 0);

    // Long pulse: latency, flag and interrupt
    bus_write(8'h18, 32'h0000_0080, ak);
    io_in[7] = 1'b1;
    k = 0;
    while (gpio_input[7] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("rise_latency", k, LAT);
    check("alt_in7", alt_in[7], 1);
    check("irq_before_flag", irq, 0);
    tick();
    check("irq_lags_flag", irq, 0);
    bus_read(8'h28, rd, ak);
    check("rise_flag_set", rd, 32'h0000_0080);
    check("irq_rise", irq, 1);
    bus_write(8'h28, 32'h0000_0080, ak);
    bus_read(8'h28, rd, ak);
    check("rise_flag_w1c", rd, 0);
    check("irq_cleared", irq, 0);

    // Falling edge coinciding with a W1C on the same bit
    io_in[7] = 1'b0;
    k = 0;
    while (gpio_input[7] !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    check("fall_latency", k, LAT);
    we = 1'b1; address = 8'h30; dataWrite = 32'h0000_0080;
    tick();
    we = 1'b0;
    bus_read(8'h30, rd, ak);
    check("fall_set_wins", rd, 32'h0000_0080);
    bus_write(8'h20, 32'h0000_0080, ak);
    tick();
    check("irq_fall", irq, 1);
    bus_write(8'h30, 32'h0000_0080, ak);
    tick();
    check("irq_fall_cleared", irq, 0);

    // Pads beyond PIN_COUNT and unmapped addresses
    bus_write(8'h1C, 32'hFFFF_FFFF, ak);
    bus_read(8'h1C, rd, ak);
    check("rise_en_hi_mask", rd, 32'h0000_003F);
    bus_read(8'h40, rd, ak);
    check("unmapped_read", rd, 0);
    check("unmapped_read_ack", ak, 1);
    bus_write(8'h40, 32'hFFFF_FFFF, ak);
    check("unmapped_write_ack", ak, 1);
    bus_read(8'h18, rd, ak);
    check("unmapped_no_effect", rd, 32'h0000_0080);
    io_in[37] = 1'b1;
    repeat (LAT + 3) tick();
    bus_read(8'h14, rd, ak);
    check("input_hi_37", rd, 32'h0000_0020);
    bus_read(8'h2C, rd, ak);
    check("rise_flag_hi_37", rd, 32'h0000_0020);
    check("irq_pad37", irq, 1);

    // Reset in the middle of filtering pad 0
    io_in[0] = 1'b1;
    repeat (S + 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_filtered0", gpio_input[0], 0);
    check("rst2_irq", irq, 0);
    bus_read(8'h28, rd, ak);
    check("rst2_no_spurious", rd, 0);
    k = 1;
    while (gpio_input[0] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("rst2_latency", k, LAT);
    bus_read(8'h1C, rd, ak);
    check("rst2_rise_en_hi", rd, 0);
    check("rst2_irq_masked", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
